tbl_lookup_rd: RTL and testbench

- Read-side lookup stage placed directly downstream of the dual-port table RAM (blk_mem_gen_0) used by the Menshen pipeline for key/action tables.
- Accepts lookup requests (index + tag) on a valid/ready handshake and drives the RAM read port (addrb/enb).
- Absorbs the fixed 1-cycle RAM read latency and returns data + tag on a backpressurable valid/ready output through an internal skid FIFO.
- Optionally snoops the RAM write port to forward same-cycle writes.

---
 rtl/tbl_lookup_pkg.sv | 21 ++
 rtl/tbl_lookup_skid_fifo.sv | 55 +++++
 rtl/tbl_lookup_rd.sv | 139 +++++++++++++
 tb/tb_tbl_lookup_rd.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbl_lookup_pkg.sv
// Shared types and helpers for the table lookup read stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tbl_lookup_pkg;

    localparam int CNT_BITS      = 32;
    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_TAG_BITS  = 8;

    // Response entry at the default table geometry, for neighbouring blocks.
    typedef struct packed {
        logic [DEF_DATA_BITS-1:0] data;
        logic [DEF_TAG_BITS-1:0]  tag;
    } rsp_entry_t;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_bits(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/tbl_lookup_skid_fifo.sv
// Synchronous skid FIFO with occupancy count; head is registered storage, no fall-through.
// Latency: a push is visible at the head one cycle later.
// Backpressure: caller must not push when full unless popping on the same edge.
module tbl_lookup_skid_fifo
    import tbl_lookup_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop    = pop & ~empty;
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and count; push and pop may land on the same edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tbl_lookup_rd.sv
// Table read stage: issues RAM port-B reads, absorbs the 1-cycle read latency, returns {data, tag}.
// Latency: 2 cycles from accept to rsp_valid; 1 lookup/cycle sustained.
// Backpressure: registered req_ready reserves a skid slot per in-flight read; optional write forwarding under TBL_LOOKUP_WR_BYPASS_EN.
module tbl_lookup_rd
    import tbl_lookup_pkg::*;
#(
    parameter int ADDR_BITS  = 5,
    parameter int DATA_BITS  = 32,
    parameter int TAG_BITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [TAG_BITS-1:0]  req_tag,
    output logic [ADDR_BITS-1:0] mem_addrb,
    output logic                 mem_enb,
    input  logic [DATA_BITS-1:0] mem_doutb,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic [TAG_BITS-1:0]  rsp_tag,
    output logic [CNT_BITS-1:0]  lookup_cnt
);

    localparam int PW = ptr_bits(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [TAG_BITS-1:0]  tag;
    } entry_t;

    logic                accept;
    logic                pop;
    logic                s1_valid;
    logic [TAG_BITS-1:0] s1_tag;
    entry_t              push_entry;
    entry_t              head;
    logic                fifo_empty;
    logic [PW:0]         fifo_count;
    logic [PW+1:0]       occ_next;
    logic [CNT_BITS-1:0] cnt_q;

    assign accept     = req_valid & req_ready;
    assign mem_enb    = accept;
    assign mem_addrb  = req_addr;
    assign pop        = rsp_valid & rsp_ready;
    assign rsp_valid  = ~fifo_empty;
    assign rsp_data   = head.data;
    assign rsp_tag    = head.tag;
    assign lookup_cnt = cnt_q;

    // Stage 1 tracks the read in flight while the RAM produces its data.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_tag <= req_tag;
            end
        end
    end

`ifdef TBL_LOOKUP_WR_BYPASS_EN
    logic                 s1_byp;
    logic [DATA_BITS-1:0] s1_wdata;

    // The RAM is read-first, so a write to the same index on the accept cycle is captured here.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_byp   <= 1'b0;
            s1_wdata <= '0;
        end else if (accept) begin
            s1_byp   <= wr_en && (wr_addr == req_addr);
            s1_wdata <= wr_data;
        end
    end
`else
    // Write snoop kept on the interface but unused in this build.
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

    // Build the entry pushed at the end of the stage-1 cycle.
    always_comb begin
        push_entry.tag  = s1_tag;
        push_entry.data = mem_doutb;
`ifdef TBL_LOOKUP_WR_BYPASS_EN
        if (s1_byp) begin
            push_entry.data = s1_wdata;
        end
`endif
    end

    tbl_lookup_skid_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (s1_valid),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-cycle occupancy counting the read that stage 1 will hold; keeps a free slot for it.
    always_comb begin
        occ_next = (PW+2)'(fifo_count) + (PW+2)'(s1_valid) + (PW+2)'(accept) - (PW+2)'(pop);
    end

    // Registered ready: no combinational path from rsp_ready.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            req_ready <= 1'b0;
        end else begin
            req_ready <= (occ_next < (PW+2)'(FIFO_DEPTH));
        end
    end

    // Accepted-lookup counter, wraps naturally.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_tbl_lookup_rd.sv
// Directed bench for tbl_lookup_rd with a read-first RAM model on the snoop/read ports.
// Latency: checks the 2-cycle accept-to-response path.
// Backpressure: exercises rsp_ready stalls and req_ready throttling.
module tb_tbl_lookup_rd;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [7:0]  req_tag;
    logic [4:0]  mem_addrb;
    logic        mem_enb;
    logic [31:0] mem_doutb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic [31:0] lookup_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [32];

    tbl_lookup_rd dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_tag    (req_tag),
        .mem_addrb  (mem_addrb),
        .mem_enb    (mem_enb),
        .mem_doutb  (mem_doutb),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .lookup_cnt (lookup_cnt)
    );

    always #5 clk = ~clk;

    // Read-first dual-port RAM model.
    always @(posedge clk) begin
        if (mem_enb) mem_doutb <= ram[mem_addrb];
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        aresetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
        #2;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_tag !== 8'h0) begin
            errors++; $display("FAIL reset_rsp: got v=%b d=%h t=%h expected 0/0/0", rsp_valid, rsp_data, rsp_tag);
        end
        checks++;
        if (lookup_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", lookup_cnt); end
        tick();
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b expected 0", req_ready); end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_single;
        ram_write(5'd3, 32'hDEADBEEF);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 5'd3; req_tag = 8'h5A;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_enb !== 1'b1 || mem_addrb !== 5'd3) begin
            errors++; $display("FAIL single_issue: got rdy=%b enb=%b addrb=%0d expected 1/1/3", req_ready, mem_enb, mem_addrb);
        end
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early: got rsp_valid=%b expected 0", rsp_valid); end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_tag !== 8'h5A) begin
            errors++; $display("FAIL single_rsp: got v=%b d=%h t=%h expected 1/deadbeef/5a", rsp_valid, rsp_data, rsp_tag);
        end
        checks++;
        if (lookup_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", lookup_cnt); end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got rsp_valid=%b expected 0", rsp_valid); end
        tick();
    endtask

    task automatic test_collision;
        logic [31:0] exp_d;
`ifdef TBL_LOOKUP_WR_BYPASS_EN
        exp_d = 32'h12345678;
`else
        exp_d = 32'h0;
`endif
        ram_write(5'd7, 32'h0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 5'd7; req_tag = 8'h77;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_tag !== 8'h77) begin
            errors++; $display("FAIL collision: got v=%b d=%h t=%h expected 1/%h/77", rsp_valid, rsp_data, rsp_tag, exp_d);
        end
        tick();
        // Plain re-read; a write during its stage-1 cycle must not change it.
        req_valid = 1'b1; req_addr = 5'd7; req_tag = 8'h78;
        tick();
        req_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678 || rsp_tag !== 8'h78) begin
            errors++; $display("FAIL reread_after_write: got v=%b d=%h t=%h expected 1/12345678/78", rsp_valid, rsp_data, rsp_tag);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic        exp_v;
        logic [31:0] exp_d;
        logic [7:0]  exp_t;
        for (int i = 0; i < 16; i++) ram_write(5'(i), 32'(i * 17));
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k < 16) begin
                req_valid = 1'b1; req_addr = 5'(k); req_tag = 8'(8'h80 + k);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 16) begin
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b expected 1", k, req_ready); end
            end
            exp_v = (k >= 2) && (k < 18);
            exp_d = 32'((k - 2) * 17);
            exp_t = 8'(8'h80 + k - 2);
            checks++;
            if (rsp_valid !== exp_v || (exp_v && (rsp_data !== exp_d || rsp_tag !== exp_t))) begin
                errors++; $display("FAIL b2b_rsp cycle %0d: got v=%b d=%h t=%h expected v=%b d=%h t=%h",
                                   k, rsp_valid, rsp_data, rsp_tag, exp_v, exp_d, exp_t);
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int n_acc;
        n_acc = 0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_valid = 1'b1; req_addr = 5'(10 + n_acc); req_tag = 8'(8'h40 + n_acc);
            @(negedge clk);
            if (req_ready === 1'b1) n_acc++;
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (n_acc != 4) begin errors++; $display("FAIL bp_accepts: got %0d expected 4", n_acc); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'hAA || rsp_tag !== 8'h40) begin
            errors++; $display("FAIL bp_hold: got rdy=%b v=%b d=%h t=%h expected 0/1/aa/40", req_ready, rsp_valid, rsp_data, rsp_tag);
        end
        tick();
        rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'(8'hAA + 17 * j) || rsp_tag !== 8'(8'h40 + j)) begin
                errors++; $display("FAIL bp_drain %0d: got v=%b d=%h t=%h expected 1/%h/%h",
                                   j, rsp_valid, rsp_data, rsp_tag, 32'(8'hAA + 17 * j), 8'(8'h40 + j));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_recover: got v=%b rdy=%b expected 0/1", rsp_valid, req_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_addr = 5'(k + 1); req_tag = 8'(8'hC0 + k);
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got rsp_valid=%b expected 1", rsp_valid); end
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || lookup_cnt !== 32'h0 || req_ready !== 1'b0 || rsp_data !== 32'h0 || rsp_tag !== 8'h0) begin
            errors++; $display("FAIL mid_reset: got v=%b cnt=%h rdy=%b d=%h t=%h expected 0/0/0/0/0",
                               rsp_valid, lookup_cnt, req_ready, rsp_data, rsp_tag);
        end
        tick();
        tick();
        @(negedge clk);
        aresetn = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_release_early: got %b expected 0", req_ready); end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_release: got %b expected 1", req_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d: got rsp_valid=%b expected 0", k, rsp_valid); end
            tick();
        end
    endtask

    task automatic test_wrap;
        force dut.cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.cnt_q;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 5'd5; req_tag = 8'h99;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (lookup_cnt !== 32'h0) begin errors++; $display("FAIL cnt_wrap: got %h expected 0", lookup_cnt); end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || rsp_tag !== 8'h99) begin
            errors++; $display("FAIL wrap_rsp: got v=%b d=%h t=%h expected 1/55/99", rsp_valid, rsp_data, rsp_tag);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
